// File: rtl/mc_dp_pkg.sv
// Shared constants for the multi-cycle datapath: ALU ops, mux select encodings
// and MIPS instruction field positions.
package mc_dp_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_NOR = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] MEM_TO_REG_ALU = 2'd0;
    localparam logic [1:0] MEM_TO_REG_MDR = 2'd1;
    localparam logic [1:0] MEM_TO_REG_PC  = 2'd2;

    localparam logic [1:0] ALU_SRC_B_REG    = 2'd0;
    localparam logic [1:0] ALU_SRC_B_WORD   = 2'd1;
    localparam logic [1:0] ALU_SRC_B_IMM    = 2'd2;
    localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned JT_MSB  = 25;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/mc_reg_file.sv
// Register file: two combinational read ports, one synchronous write port,
// register 0 hard-wired to zero.
module mc_reg_file #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REG_NUM = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(REG_NUM)-1:0] rd_addr_a,
    output logic [WIDTH-1:0]           rd_data_a,
    input  logic [$clog2(REG_NUM)-1:0] rd_addr_b,
    output logic [WIDTH-1:0]           rd_data_b,
    input  logic                       wr_en,
    input  logic [$clog2(REG_NUM)-1:0] wr_addr,
    input  logic [WIDTH-1:0]           wr_data
);

    logic [WIDTH-1:0] regs [REG_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // No write bypass: a same-cycle read returns the old contents.
    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/multicycle_data_path.sv
// Multi-cycle MIPS datapath: PC, IR, MDR, A, B, ALUOut and register file,
// sequenced by an external microprogrammed controller over a shared memory port.
module multicycle_data_path
    import mc_dp_pkg::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter int unsigned     REG_NUM  = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic             branch_ne,
    input  logic             iord,
    input  logic             ir_write,
    input  logic [1:0]       reg_dst,
    input  logic [1:0]       mem_to_reg,
    input  logic             reg_write,
    input  logic             alu_src_a,
    input  logic [1:0]       alu_src_b,
    input  logic [2:0]       alu_control,
    input  logic [1:0]       pc_source,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] data_out,
    output logic [31:0]      inst_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(REG_NUM);

    logic [WIDTH-1:0] pc, mdr, a_r, b_r, alu_out_r;
    logic [31:0]      ir;
    logic [WIDTH-1:0] rd_data_a, rd_data_b, wr_data;
    logic [4:0]       rs_f, rt_f, rd_f, wr_f;
    logic [WIDTH-1:0] imm_sext, imm_sh, src_a, src_b, alu_y, jump_target, pc_next;
    logic             alu_ovf, pc_load;

    assign rs_f = ir[RS_MSB:RS_LSB];
    assign rt_f = ir[RT_MSB:RT_LSB];
    assign rd_f = ir[RD_MSB:RD_LSB];

    // Write-back address and data selection; unused codes fall back to rt / ALUOut.
    always_comb begin
        wr_f    = rt_f;
        wr_data = alu_out_r;
        case (reg_dst)
            REG_DST_RD: wr_f = rd_f;
            REG_DST_RA: wr_f = REG_RA;
            default:    wr_f = rt_f;
        endcase
        case (mem_to_reg)
            MEM_TO_REG_MDR: wr_data = mdr;
            MEM_TO_REG_PC:  wr_data = pc;
            default:        wr_data = alu_out_r;
        endcase
    end

    mc_reg_file #(
        .WIDTH  (WIDTH),
        .REG_NUM(REG_NUM)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst),
        .rd_addr_a(AW'(rs_f)),
        .rd_data_a(rd_data_a),
        .rd_addr_b(AW'(rt_f)),
        .rd_data_b(rd_data_b),
        .wr_en    (reg_write),
        .wr_addr  (AW'(wr_f)),
        .wr_data  (wr_data)
    );

    assign imm_sext    = {{(WIDTH-16){ir[IMM_MSB]}}, ir[IMM_MSB:0]};
    assign imm_sh      = {imm_sext[WIDTH-3:0], 2'b00};
    assign jump_target = {pc[WIDTH-1:28], ir[JT_MSB:0], 2'b00};
    assign src_a       = alu_src_a ? a_r : pc;

    always_comb begin
        src_b = b_r;
        case (alu_src_b)
            ALU_SRC_B_WORD: src_b = WIDTH'(WIDTH / 8);
            ALU_SRC_B_IMM:  src_b = imm_sext;
            ALU_SRC_B_IMM_SH: src_b = imm_sh;
            default:        src_b = b_r;
        endcase
    end

    // ALU; overflow is only meaningful for signed add and subtract.
    always_comb begin
        alu_y   = '0;
        alu_ovf = 1'b0;
        case (alu_control)
            ALU_AND: alu_y = src_a & src_b;
            ALU_OR:  alu_y = src_a | src_b;
            ALU_ADD: begin
                alu_y   = src_a + src_b;
                alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_y[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_XOR: alu_y = src_a ^ src_b;
            ALU_NOR: alu_y = ~(src_a | src_b);
            ALU_SRL: alu_y = src_a >> src_b[4:0];
            ALU_SUB: begin
                alu_y   = src_a - src_b;
                alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_y[WIDTH-1] != src_a[WIDTH-1]);
            end
            default: alu_y = WIDTH'($signed(src_a) < $signed(src_b));
        endcase
    end

    assign zero = (alu_y == '0);

    always_comb begin
        pc_next = alu_out_r;
        case (pc_source)
            PC_SRC_ALU:  pc_next = alu_y;
            PC_SRC_JUMP: pc_next = jump_target;
            default:     pc_next = alu_out_r;
        endcase
    end

    assign pc_load = pc_write | (pc_write_cond & (zero ^ branch_ne));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            ir        <= '0;
            mdr       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            alu_out_r <= '0;
        end else begin
            mdr       <= data_in;
            a_r       <= rd_data_a;
            b_r       <= rd_data_b;
            alu_out_r <= alu_y;
            if (ir_write) ir <= data_in[31:0];
            if (pc_load)  pc <= pc_next;
        end
    end

    assign mem_addr = iord ? alu_out_r : pc;
    assign data_out = b_r;
    assign inst_out = ir;
    assign pc_out   = pc;
    assign alu_out  = alu_y;
    assign overflow = alu_ovf;

endmodule
